// File: rtl/mult_unit_pkg.sv
// Shared types and constants for the sequential Booth multiplier.
package mult_unit_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned EXT_W     = 33;
  localparam int unsigned ITER_LAST = 32;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Booth working register {A, Q, q_-1}
  typedef struct packed {
    logic [EXT_W-1:0] a;
    logic [EXT_W-1:0] q;
    logic             qm1;
  } booth_t;

  function automatic logic [EXT_W-1:0] ext_op(input logic [WORD_W-1:0] v,
                                               input logic sgn);
    return {sgn & v[WORD_W-1], v};
  endfunction

endpackage

// File: rtl/mult_unit_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then arithmetic shift.
module booth_step
  import mult_unit_pkg::*;
(
  input  booth_t           cur,
  input  logic [EXT_W-1:0] m,
  output booth_t           nxt_c
);

  logic [EXT_W-1:0] sum;

  always_comb begin
    sum = cur.a;
    case ({cur.q[0], cur.qm1})
      2'b01:   sum = cur.a + m;
      2'b10:   sum = cur.a - m;
      default: sum = cur.a;
    endcase
    nxt_c = booth_t'({sum[EXT_W-1], sum, cur.q});
  end

endmodule

// File: rtl/mult_unit.sv
// Sequential 32x32 signed/unsigned multiplier, 33 Booth steps, state updates on falling clk.
module mult_unit
  import mult_unit_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              MultStart,
  input  logic              MultSigned,
  input  logic [WORD_W-1:0] multiplicando,
  input  logic [WORD_W-1:0] multiplicador,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo,
  output logic              MultEnd
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  booth_t           acc, acc_n, step_c;
  logic [EXT_W-1:0] m_reg, m_n;
  logic [WORD_W-1:0] hi_n, lo_n;
  logic             end_n;

  booth_step u_step (
    .cur   (acc),
    .m     (m_reg),
    .nxt_c (step_c)
  );

  // State and datapath registers
  always_ff @(negedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      m_reg   <= '0;
      hi      <= '0;
      lo      <= '0;
      MultEnd <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      acc     <= acc_n;
      m_reg   <= m_n;
      hi      <= hi_n;
      lo      <= lo_n;
      MultEnd <= end_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    acc_n   = acc;
    m_n     = m_reg;
    hi_n    = hi;
    lo_n    = lo;
    end_n   = 1'b0;
    case (state)
      IDLE: begin
        if (MultStart) begin
          m_n     = ext_op(multiplicando, MultSigned);
          acc_n   = '{a: '0, q: ext_op(multiplicador, MultSigned), qm1: 1'b0};
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        acc_n = step_c;
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(ITER_LAST)) state_n = DONE;
      end
      DONE: begin
        // Low 64 bits of the 66-bit {A,Q} product
        hi_n    = {acc.a[WORD_W-2:0], acc.q[EXT_W-1]};
        lo_n    = acc.q[WORD_W-1:0];
        end_n   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit with a transaction-level product model.
module tb_mult_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MultStart = 1'b0;
  logic        MultSigned = 1'b0;
  logic [31:0] multiplicando = '0;
  logic [31:0] multiplicador = '0;
  logic [31:0] hi, lo;
  logic        MultEnd;

  int errors = 0;
  int checks = 0;

  mult_unit dut (
    .clk           (clk),
    .reset         (reset),
    .MultStart     (MultStart),
    .MultSigned    (MultSigned),
    .multiplicando (multiplicando),
    .multiplicador (multiplicador),
    .hi            (hi),
    .lo            (lo),
    .MultEnd       (MultEnd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: an accepted start yields its full 64-bit product 34 falling edges later
  int          edge_n = 0;
  bit          busy = 0;
  int          done_at = 0;
  logic [63:0] prod = '0;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  logic        exp_end = 1'b0;
  bit          cmp_en = 0;

  always @(negedge clk) begin
    edge_n++;
    exp_end = 1'b0;
    if (reset) begin
      busy = 0;
      exp_hi = '0;
      exp_lo = '0;
    end else if (!busy) begin
      if (MultStart) begin
        busy = 1;
        done_at = edge_n + 34;
        if (MultSigned)
          prod = {{32{multiplicando[31]}}, multiplicando} * {{32{multiplicador[31]}}, multiplicador};
        else
          prod = {32'b0, multiplicando} * {32'b0, multiplicador};
      end
    end else if (edge_n == done_at) begin
      busy = 0;
      exp_end = 1'b1;
      {exp_hi, exp_lo} = prod;
    end
  end

  always @(posedge clk) begin
    if (cmp_en) begin
      chk("cyc_hi", 64'(hi), 64'(exp_hi));
      chk("cyc_lo", 64'(lo), 64'(exp_lo));
      chk("cyc_end", 64'(MultEnd), 64'(exp_end));
    end
  end

  // Start one op, check held result mid-run, then the final result and latency
  task automatic run_op(input string nm, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ph, input logic [31:0] pl,
                        input logic [31:0] eh, input logic [31:0] el);
    int start_e;
    bit seen;
    @(posedge clk);
    MultStart = 1'b1;
    MultSigned = sgn;
    multiplicando = a;
    multiplicador = b;
    start_e = edge_n + 1;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      MultStart = 1'b0;
      multiplicando = ~a;
      multiplicador = b ^ 32'h5a5a_5a5a;
      MultSigned = ~sgn;
      if (i == 20) begin
        chk({nm, "_hold_hi"}, 64'(hi), 64'(ph));
        chk({nm, "_hold_lo"}, 64'(lo), 64'(pl));
      end
      if (MultEnd) seen = 1;
    end
    chk({nm, "_seen"}, 64'(seen), 64'(1));
    if (seen) begin
      chk({nm, "_lat"}, 64'(edge_n - start_e), 64'(34));
      chk({nm, "_hi"}, 64'(hi), 64'(eh));
      chk({nm, "_lo"}, 64'(lo), 64'(el));
    end
  endtask

  initial begin
    int end1, end2, cnt_end;
    bit got_end;
    @(negedge clk);
    @(posedge clk);
    cmp_en = 1;
    @(posedge clk);
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_end", 64'(MultEnd), 64'(0));
    reset = 1'b0;

    run_op("s7xm3", 1'b1, 32'd7, 32'hFFFF_FFFD, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("smin2", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'h4000_0000, 32'h0);
    run_op("umax2", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h4000_0000, 32'h0, 32'hFFFF_FFFE, 32'h1);
    run_op("smax2", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 32'h0, 32'h1);
    run_op("zero", 1'b0, 32'h0, 32'h1234_5678, 32'h0, 32'h1, 32'h0, 32'h0);
    run_op("u9x9", 1'b0, 32'd9, 32'd9, 32'h0, 32'h0, 32'h0, 32'd81);

    // Reset partway through RUN aborts with no completion pulse
    @(posedge clk);
    MultStart = 1'b1;
    MultSigned = 1'b0;
    multiplicando = 32'd100;
    multiplicador = 32'd100;
    @(posedge clk);
    MultStart = 1'b0;
    repeat (10) @(posedge clk);
    reset = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    got_end = 0;
    repeat (40) begin
      @(posedge clk);
      if (MultEnd) got_end = 1;
    end
    chk("abort_noend", 64'(got_end), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    run_op("u3x5", 1'b0, 32'd3, 32'd5, 32'h0, 32'h0, 32'h0, 32'd15);

    // MultStart held high: back-to-back operations
    @(posedge clk);
    MultStart = 1'b1;
    MultSigned = 1'b0;
    multiplicando = 32'd6;
    multiplicador = 32'd7;
    repeat (10) @(posedge clk);
    multiplicando = 32'd2;
    multiplicador = 32'd2;
    end1 = 0;
    end2 = 0;
    cnt_end = 0;
    for (int i = 0; i < 100 && cnt_end < 2; i++) begin
      @(posedge clk);
      if (MultEnd) begin
        cnt_end++;
        if (cnt_end == 1) begin
          end1 = edge_n;
          chk("b2b_lo1", 64'(lo), 64'(42));
        end else begin
          end2 = edge_n;
          chk("b2b_lo2", 64'(lo), 64'(4));
          MultStart = 1'b0;
        end
      end
    end
    chk("b2b_count", 64'(cnt_end), 64'(2));
    chk("b2b_gap", 64'(end2 - end1), 64'(35));
    MultStart = 1'b0;
    repeat (40) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates occur on the falling edge of clk, matching the divider's timing.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset, sampled on the clk update edge.
REQ-003 SHALL have port MultStart, input, 1, level request to start a multiplication.
REQ-004 SHALL have port MultSigned, input, 1: 1 selects signed (mult), 0 selects unsigned (multu).
REQ-005 SHALL have port multiplicando, input, 32, multiplicand operand.
REQ-006 SHALL have port multiplicador, input, 32, multiplier operand.
REQ-007 SHALL have port hi, output reg, 32, upper 64-bit product word (to MFHI).
REQ-008 SHALL have port lo, output reg, 32, lower 64-bit product word (to MFLO).
REQ-009 SHALL have port MultEnd, output reg, 1, one-cycle completion pulse.

Function
REQ-010 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-011 In IDLE with MultStart=1, SHALL capture both operands, extended to 33 bits per MultSigned (sign-extend if 1, zero-extend if 0), and go to RUN.
REQ-012 On entering RUN, SHALL clear accumulator A[32:0], load Q[32:0]=extended multiplier and q_-1=0, and load iteration counter=0.
REQ-013 Each RUN cycle SHALL perform one radix-2 Booth step:
- {Q[0],q_-1}=01: A+=M.
- {Q[0],q_-1}=10: A-=M.
- Otherwise A is unchanged.
- Then arithmetic-shift {A,Q,q_-1} right by 1.
REQ-014 All A arithmetic SHALL be 33-bit two's complement, with no overflow detection.
REQ-015 After 33 RUN cycles (counter 0..32), SHALL go to DONE.
REQ-016 In DONE, SHALL assign {hi,lo}={A,Q}[63:0], assert MultEnd for exactly one cycle, and return to IDLE.
REQ-017 Latency: MultStart sampled at edge N SHALL give MultEnd=1 and valid hi/lo after edge N+34.
REQ-018 hi and lo SHALL hold their last result until the next DONE and SHALL NOT change during RUN.
REQ-019 Changes to MultStart, operands or MultSigned during RUN/DONE SHALL be ignored; the operation completes with the captured values.
REQ-020 If MultStart=1 in IDLE on the cycle after DONE, SHALL start a new operation (level-triggered, back-to-back allowed).
REQ-021 A zero operand SHALL run the full 33 cycles; there is no early termination.

Reset
REQ-022 reset=1 SHALL force state=IDLE, counter=0, A=Q=M=0, q_-1=0, hi=0, lo=0 and MultEnd=0, taking priority over MultStart.
REQ-023 reset asserted mid-RUN or in DONE SHALL abort the operation with no MultEnd pulse and clear hi/lo to 0.

Structure
REQ-024 A shared package SHALL hold the state encoding (IDLE/RUN/DONE), WORD_W=32, EXT_W=33 and ITER_LAST=32.
REQ-025 The Booth add/sub-and-shift datapath SHALL be one combinational sub-module, booth_step, which takes {A,Q,q_-1} and M and returns the next {A,Q,q_-1}.
REQ-026 booth_step SHALL have no state; all registers SHALL reside in mult_unit.

Verification
REQ-027 Signed, 7 x 0xFFFFFFFD (-3) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, MultEnd pulse exactly 34 edges after start.
REQ-028 Signed, 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-029 Unsigned, 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; the same operands signed -> hi=0, lo=1.
REQ-030 0 x 0x12345678 after a prior nonzero result -> hi=lo=0, and hi/lo keep the prior values until the DONE cycle.
REQ-031 reset pulsed at RUN cycle 10 -> no MultEnd, hi=lo=0, IDLE; a subsequent 3 x 5 -> lo=15, hi=0.
REQ-032 MultStart held high across two operations (6 x 7, then operands changed to 2 x 2 mid-RUN) -> first lo=42, second lo=4, with MultEnd pulses 35 edges apart.
